// File: rtl/bus_mem_pkg.sv
// Shared widths, memory depth and state encoding for the bus_mem responder.
package bus_mem_pkg;

    localparam int WORD_SIZE = 8;
    localparam int ADDR_SIZE = 8;
    localparam int MEM_DEPTH = 2 ** (ADDR_SIZE - 1);

    typedef enum logic {
        BM_BOOT = 1'b0,
        BM_RUN  = 1'b1
    } bm_state_e;

endpackage

// File: rtl/bus_mem_if.sv
// CPU address/strobe and host load-port signals shared between bus_mem and its master.
interface bus_mem_if #(
    parameter int WORD_SIZE = bus_mem_pkg::WORD_SIZE,
    parameter int ADDR_SIZE = bus_mem_pkg::ADDR_SIZE
);
    logic [ADDR_SIZE-1:0] addr_bus;
    logic                 wr_en;
    logic                 prog_valid;
    logic [WORD_SIZE-1:0] prog_data;
    logic                 prog_ready;
    logic                 boot_done;
    logic                 addr_err;

    modport master (
        output addr_bus, wr_en, prog_valid, prog_data,
        input  prog_ready, boot_done, addr_err
    );

    modport slave (
        input  addr_bus, wr_en, prog_valid, prog_data,
        output prog_ready, boot_done, addr_err
    );
endinterface

// File: rtl/bus_mem_fifo.sv
// Synchronous FIFO feeding boot words; DEPTH must be a power of two so pointers wrap for free.
module bus_mem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ready_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A pop on the same edge frees the slot, so a full FIFO may still accept.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = store_q[rd_ptr_q];
    assign ready_o = ready_q;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= (count_d != CNT_W'(DEPTH));
        end
    end

    // NOTE: storage arrays carry no reset so they map onto plain RAM; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) store_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/bus_mem.sv
// CPU-bus memory responder: boot sweep filled from a host load FIFO, then tri-state read/write.
// Optional sticky odd-address flag enabled by defining BUS_MEM_ADDR_CHECK_EN.
module bus_mem
    import bus_mem_pkg::*;
#(
    parameter int WORD_SIZE  = bus_mem_pkg::WORD_SIZE,
    parameter int ADDR_SIZE  = bus_mem_pkg::ADDR_SIZE,
    parameter int LOAD_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_mem_if.slave             bus,
    inout  wire  [WORD_SIZE-1:0] data_bus
);
    localparam int MEM_WORDS = 2 ** (ADDR_SIZE - 1);
    localparam int IDX_W     = ADDR_SIZE - 1;

    bm_state_e            state_q;
    logic                 boot_done_q;
    logic [WORD_SIZE-1:0] mem_q [MEM_WORDS];
    logic [IDX_W-1:0]     idx;
    logic [WORD_SIZE-1:0] fifo_head, mem_wdata;
    logic                 fifo_empty, fifo_pop, boot_wr, run_rd;
    logic                 unused_fifo_full;

    assign idx      = bus.addr_bus[ADDR_SIZE-1:1];
    assign boot_wr  = (state_q == BM_BOOT) && bus.wr_en;
    assign fifo_pop = boot_wr && !fifo_empty;
    assign run_rd   = (state_q == BM_RUN) && !bus.wr_en;

    bus_mem_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (LOAD_DEPTH)
    ) u_load_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.prog_valid),
        .pop_i   (fifo_pop),
        .data_i  (bus.prog_data),
        .head_o  (fifo_head),
        .full_o  (unused_fifo_full),
        .empty_o (fifo_empty),
        .ready_o (bus.prog_ready)
    );

    // An empty FIFO during boot writes zero rather than stalling the CPU sweep.
    assign mem_wdata = (state_q == BM_BOOT) ? (fifo_empty ? '0 : fifo_head) : data_bus;

    always_ff @(posedge clk) begin
        if (rst && bus.wr_en) mem_q[idx] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BM_BOOT;
            boot_done_q <= 1'b0;
        end else if (boot_wr && (&idx)) begin
            state_q     <= BM_RUN;
            boot_done_q <= 1'b1;
        end
    end

    assign data_bus      = run_rd ? mem_q[idx] : 'z;
    assign bus.boot_done = boot_done_q;

`ifdef BUS_MEM_ADDR_CHECK_EN
    logic addr_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 addr_err_q <= 1'b0;
        else if (bus.addr_bus[0]) addr_err_q <= 1'b1;
    end

    assign bus.addr_err = addr_err_q;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = bus.addr_bus[0];
    assign bus.addr_err    = 1'b0;
`endif
endmodule

// File: tb/tb_bus_mem.sv
// Self-checking bench for bus_mem: directed boot/read/write/FIFO/reset cases plus randomized RUN traffic.
module tb_bus_mem;
    import bus_mem_pkg::*;

    localparam int W  = 8;
    localparam int A  = 8;
    localparam int LD = 4;
    localparam int NW = 2 ** (A - 1);
    localparam logic [W-1:0] IDLE = 8'hFF;  // pulled-up bus value when nobody drives

    logic         clk = 1'b0;
    logic         rst;
    logic         tb_drive;
    logic [W-1:0] tb_wdata;
    wire  [W-1:0] data_bus;

    bus_mem_if #(.WORD_SIZE(W), .ADDR_SIZE(A)) bus ();

    bus_mem #(
        .WORD_SIZE  (W),
        .ADDR_SIZE  (A),
        .LOAD_DEPTH (LD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .data_bus (data_bus)
    );

    assign data_bus = tb_drive ? tb_wdata : 'z;
    pullup (data_bus);

    always #5 clk = ~clk;

    // Reference model: memory as an array, load FIFO as a queue, state as flags.
    logic [W-1:0] m_mem   [NW];
    bit           m_known [NW];
    logic [W-1:0] m_fifo  [$];
    bit           m_boot, m_done, m_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [A-1:0] addr;
        logic         wr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_boot = 1'b1;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        int idx;
        bit pop, push;
        idx  = int'(bus.addr_bus) / 2;
        pop  = m_boot && bus.wr_en && (m_fifo.size() > 0);
        push = bus.prog_valid && ((m_fifo.size() < LD) || pop);
        if (bus.wr_en) begin
            if (m_boot) m_mem[idx] = (m_fifo.size() > 0) ? m_fifo[0] : '0;
            else        m_mem[idx] = tb_wdata;
            m_known[idx] = 1'b1;
        end
        if (pop)  void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(bus.prog_data);
        if (m_boot && bus.wr_en && (idx == NW - 1)) begin
            m_boot = 1'b0;
            m_done = 1'b1;
        end
`ifdef BUS_MEM_ADDR_CHECK_EN
        if (bus.addr_bus[0]) m_err = 1'b1;
`endif
    endtask

    task automatic drive(input logic [A-1:0] addr, input logic wr, input logic [W-1:0] wd,
                         input logic pv, input logic [W-1:0] pd);
        bus.addr_bus   = addr;
        bus.wr_en      = wr;
        tb_wdata       = wd;
        tb_drive       = wr && !m_boot;
        bus.prog_valid = pv;
        bus.prog_data  = pd;
        #1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".prog_ready"}, bus.prog_ready, (m_fifo.size() < LD));
        check({tag, ".boot_done"}, bus.boot_done, m_done);
        check({tag, ".addr_err"}, bus.addr_err, m_err);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) m_known[i] = 1'b0;
        vecs[0]  = '{8'h04, 1'b0, 8'h00, 8'hB2};
        vecs[1]  = '{8'h06, 1'b0, 8'h00, 8'hC3};
        vecs[2]  = '{8'h02, 1'b0, 8'h00, 8'hA1};
        vecs[3]  = '{8'h08, 1'b0, 8'h00, 8'h00};
        vecs[4]  = '{8'hFE, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{8'h10, 1'b1, 8'h5A, 8'h00};
        vecs[6]  = '{8'h10, 1'b0, 8'h00, 8'h5A};
        vecs[7]  = '{8'h11, 1'b0, 8'h00, 8'h5A};
        vecs[8]  = '{8'h12, 1'b1, 8'h3C, 8'h00};
        vecs[9]  = '{8'h12, 1'b0, 8'h00, 8'h3C};
        vecs[10] = '{8'h10, 1'b0, 8'h00, 8'h5A};

        // Power-on reset
        rst = 1'b1;
        model_reset();
        drive('0, 1'b0, '0, 1'b0, '0);
        #1 rst = 1'b0;
        #20;
        check_outs("reset");
        check("reset.data_bus", data_bus, IDLE);
        @(posedge clk);
        #1 rst = 1'b1;

        // Preload three boot words
        drive('0, 1'b0, '0, 1'b1, 8'hA1); tick();
        drive('0, 1'b0, '0, 1'b1, 8'hB2); tick();
        drive('0, 1'b0, '0, 1'b1, 8'hC3); tick();
        check_outs("preload");

        // Boot sweep 2..254; the block must never drive during BOOT
        for (int a = 2; a <= 254; a += 2) begin
            drive(A'(a), 1'b1, '0, 1'b0, '0);
            if (a <= 8 || a == 254) check($sformatf("boot_nodrive@%0h", a), data_bus, IDLE);
            if (a == 254) check("boot_done_before_last", bus.boot_done, 1'b0);
            tick();
        end
        check("boot_done_after_last", bus.boot_done, 1'b1);
        check_outs("boot_end");

        // Table-driven RUN reads/writes
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b0, '0);
            if (!vecs[i].wr) check($sformatf("vec%0d.data", i), data_bus, vecs[i].exp);
            tick();
        end
        check_outs("table");

        // RUN write with the CPU not driving: the block must stay off the bus
        drive(8'h30, 1'b1, IDLE, 1'b0, '0);
        tb_drive = 1'b0;
        #1;
        check("run_write_hiz", data_bus, IDLE);
        tick();

        // Randomized RUN traffic, with load pushes but no pops
        for (int i = 0; i < 300; i++) begin
            logic [A-1:0] ra;
            logic         rw, pv;
            ra = A'($urandom_range(2, 255));
            rw = 1'($urandom_range(0, 1));
            pv = 1'($urandom_range(0, 1));
            drive(ra, rw, W'($urandom_range(0, 254)), pv, W'($urandom));
            if (!rw && m_known[ra >> 1])
                check($sformatf("rand%0d.data@%0h", i, ra), data_bus, m_mem[ra >> 1]);
            tick();
            check_outs($sformatf("rand%0d", i));
        end

        // Mid-operation reset: bus released at once, memory survives
        drive(8'h10, 1'b1, 8'h5A, 1'b0, '0); tick();
        drive(8'h10, 1'b0, '0, 1'b0, '0);
        check("pre_reset.data", data_bus, 8'h5A);
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_reset.data_bus", data_bus, IDLE);
        check_outs("mid_reset");
        drive(8'h10, 1'b1, 8'h00, 1'b0, '0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Load FIFO full in BOOT: fifth word ignored, one pop reopens it
        drive('0, 1'b0, '0, 1'b1, 8'h11); tick();
        drive('0, 1'b0, '0, 1'b1, 8'h22); tick();
        drive('0, 1'b0, '0, 1'b1, 8'h33); tick();
        check("ready_at_3", bus.prog_ready, 1'b1);
        drive('0, 1'b0, '0, 1'b1, 8'h44); tick();
        check("ready_full", bus.prog_ready, 1'b0);
        drive('0, 1'b0, '0, 1'b1, 8'h55); tick();
        check("ready_full_5th", bus.prog_ready, 1'b0);
        drive(8'h20, 1'b1, '0, 1'b0, '0);
        check("ready_before_pop", bus.prog_ready, 1'b0);
        tick();
        check("ready_after_pop", bus.prog_ready, 1'b1);
        drive(8'hFE, 1'b1, '0, 1'b0, '0); tick();
        check_outs("reboot");
        check("reboot_done", bus.boot_done, 1'b1);

        drive(8'h20, 1'b0, '0, 1'b0, '0);
        check("fifo_word1", data_bus, 8'h11);
        tick();
        drive(8'hFE, 1'b0, '0, 1'b0, '0);
        check("fifo_word2", data_bus, 8'h22);
        tick();
        drive(8'h10, 1'b0, '0, 1'b0, '0);
        check("survive_reset", data_bus, 8'h5A);
        tick();

        // Odd address: aliased read, sticky error flag only when the check is built in
        check("err_clear", bus.addr_err, 1'b0);
        drive(8'h05, 1'b0, '0, 1'b0, '0);
        check("odd_read.data", data_bus, m_mem[2]);
        tick();
`ifdef BUS_MEM_ADDR_CHECK_EN
        check("err_set", bus.addr_err, 1'b1);
`else
        check("err_tied", bus.addr_err, 1'b0);
`endif
        drive(8'h06, 1'b0, '0, 1'b0, '0); tick();
        check_outs("err_sticky");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
